// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the arbiter that multiplexes instruction fetch and data
// accesses onto one single-ported 16-bit memory.
package mem_port_arbiter_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_FETCH = 2'd1,
    ARB_DATA  = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } memreq_t;

  // The memory is word organised; an odd byte address selects its containing word.
  function automatic logic [15:0] word_align(input logic [15:0] addr);
    return addr & 16'hFFFE;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the arbiter; the arbiter takes the
// slave view, the requesters plus memory model take the master view.
interface mem_port_arbiter_if;

  logic        halt_sys;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_gnt;
  logic        if_valid;
  logic [15:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_gnt;
  logic        d_valid;
  logic [15:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        stall_fetch;
  logic        busy;

  modport master (
    output halt_sys, if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, stall_fetch, busy
  );

  modport slave (
    input  halt_sys, if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, stall_fetch, busy
  );

endinterface

// File: rtl/arb_wait_counter.sv
// Loadable saturating 4-bit counter: DIR=0 counts down to zero, DIR=1 counts
// up to LIMIT; term flags the end value in either direction.
module arb_wait_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter bit               DIR   = 1'b0,
  parameter logic [CNT_W-1:0] LIMIT = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             term
);

  logic [CNT_W-1:0] count;

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      if (DIR) begin
        if (count != LIMIT) count <= count + 1'b1;
      end else if (count != '0) begin
        count <= count - 1'b1;
      end
    end
  end

  assign term = DIR ? (count == LIMIT) : (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch port and the data port,
// running each access for WAIT_CYCLES cycles and returning read data.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES  = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("mem_port_arbiter: WAIT_CYCLES must be in 1..15");
  end
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve
    $error("mem_port_arbiter: STARVE_LIMIT must be in 1..15");
  end

  localparam logic [CNT_W-1:0] WAIT_LOAD  = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  arb_state_e state;
  memreq_t    req_q;
  logic       wait_done;
  logic       starve_sat;
  logic       grant_d;
  logic       grant_f;

  // Data wins by default; once STARVE_LIMIT data grants have passed a waiting fetch, fetch wins.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    grant_d = 1'b0;
    grant_f = 1'b0;
    if (state == ARB_IDLE && !bus.halt_sys) begin
      grant_d = bus.d_req && (!bus.if_req || !starve_sat);
      grant_f = bus.if_req && !grant_d;
    end
  end

  arb_wait_counter #(.DIR(1'b0), .LIMIT('0)) u_wait (
    .clk      (clk),
    .rst      (rst),
    .load     (grant_d | grant_f),
    .load_val (WAIT_LOAD),
    .en       (state != ARB_IDLE),
    .term     (wait_done)
  );

  arb_wait_counter #(.DIR(1'b1), .LIMIT(STARVE_MAX)) u_starve (
    .clk      (clk),
    .rst      (rst),
    .load     (grant_f),
    .load_val ('0),
    .en       (grant_d & bus.if_req),
    .term     (starve_sat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ARB_IDLE;
      req_q        <= '0;
      bus.if_gnt   <= 1'b0;
      bus.if_valid <= 1'b0;
      bus.if_rdata <= '0;
      bus.d_gnt    <= 1'b0;
      bus.d_valid  <= 1'b0;
      bus.d_rdata  <= '0;
      bus.mem_en   <= 1'b0;
      bus.mem_we   <= 1'b0;
      bus.busy     <= 1'b0;
    end else begin
      bus.if_gnt   <= 1'b0;
      bus.d_gnt    <= 1'b0;
      bus.if_valid <= 1'b0;
      bus.d_valid  <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (grant_d) begin
            state      <= ARB_DATA;
            req_q      <= '{we: bus.d_we, addr: word_align(bus.d_addr), wdata: bus.d_wdata};
            bus.d_gnt  <= 1'b1;
            bus.mem_en <= 1'b1;
            bus.mem_we <= bus.d_we;
            bus.busy   <= 1'b1;
          end else if (grant_f) begin
            state      <= ARB_FETCH;
            req_q      <= '{we: 1'b0, addr: word_align(bus.if_addr), wdata: '0};
            bus.if_gnt <= 1'b1;
            bus.mem_en <= 1'b1;
            bus.mem_we <= 1'b0;
            bus.busy   <= 1'b1;
          end
        end
        ARB_FETCH: begin
          if (wait_done) begin
            state        <= ARB_IDLE;
            bus.if_rdata <= bus.mem_rdata;
            bus.if_valid <= 1'b1;
            bus.mem_en   <= 1'b0;
            bus.busy     <= 1'b0;
          end
        end
        ARB_DATA: begin
          // The strobe drops together with the valid pulse, so a store reports done only after its write.
          if (wait_done) begin
            state       <= ARB_IDLE;
            if (!req_q.we) bus.d_rdata <= bus.mem_rdata;
            bus.d_valid <= 1'b1;
            bus.mem_en  <= 1'b0;
            bus.mem_we  <= 1'b0;
            bus.busy    <= 1'b0;
          end
        end
        default: begin
          state      <= ARB_IDLE;
          bus.mem_en <= 1'b0;
          bus.mem_we <= 1'b0;
          bus.busy   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_addr    = req_q.addr;
  assign bus.mem_wdata   = req_q.wdata;
  assign bus.stall_fetch = bus.if_req & ~bus.if_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random
// traffic, compared against a timestamp-based transaction model.
module tb_mem_port_arbiter;

  localparam int WAIT   = 3;
  localparam int STARVE = 4;

  logic clk = 1'b0;
  logic rst;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.WAIT_CYCLES(WAIT), .STARVE_LIMIT(STARVE)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read, write on the clock edge while strobed.
  logic [15:0] mem     [256];
  logic [15:0] ref_mem [256];
  logic        mem_init;

  assign bus.mem_rdata = mem[bus.mem_addr[8:1]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= ref_mem[i];
    end else if (bus.mem_en && bus.mem_we) begin
      mem[bus.mem_addr[8:1]] <= bus.mem_wdata;
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model: one access record, described by the cycle it was sampled in.
  bit          cur_active, cur_data, cur_we;
  int          cur_n, next_idle, starve;
  logic [15:0] cur_addr, cur_wdata, cur_rdata;
  logic [15:0] exp_if_rdata, exp_d_rdata;

  bit   auto_drop = 1'b1;
  bit   drop_if, drop_d;
  int   we_cnt, dv_cnt;
  int   last_ifgnt_cyc, last_dgnt_cyc, last_dv_cyc;
  byte  gnt_log[$];
  string exp_seq = "DDDDFD";

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_if_gnt"},   32'(bus.if_gnt),      32'(0));
    check({tag, "_if_valid"}, 32'(bus.if_valid),    32'(0));
    check({tag, "_if_rdata"}, 32'(bus.if_rdata),    32'(0));
    check({tag, "_d_gnt"},    32'(bus.d_gnt),       32'(0));
    check({tag, "_d_valid"},  32'(bus.d_valid),     32'(0));
    check({tag, "_d_rdata"},  32'(bus.d_rdata),     32'(0));
    check({tag, "_mem_en"},   32'(bus.mem_en),      32'(0));
    check({tag, "_mem_we"},   32'(bus.mem_we),      32'(0));
    check({tag, "_mem_addr"}, 32'(bus.mem_addr),    32'(0));
    check({tag, "_stall"},    32'(bus.stall_fetch), 32'(0));
    check({tag, "_busy"},     32'(bus.busy),        32'(0));
  endtask

  task automatic model_reset();
    cur_active   = 1'b0;
    starve       = 0;
    exp_if_rdata = '0;
    exp_d_rdata  = '0;
    next_idle    = cyc;
    drop_if      = 1'b0;
    drop_d       = 1'b0;
  endtask

  // Compare this cycle's outputs with the model, then let the model arbitrate.
  task automatic eval();
    bit e_en, e_we, e_ifg, e_dg, e_ifv, e_dv;
    #1;
    e_en  = cur_active && (cyc >= cur_n + 1) && (cyc <= cur_n + WAIT);
    e_we  = e_en && cur_data && cur_we;
    e_ifg = cur_active && !cur_data && (cyc == cur_n + 1);
    e_dg  = cur_active && cur_data && (cyc == cur_n + 1);
    e_ifv = cur_active && !cur_data && (cyc == cur_n + WAIT + 1);
    e_dv  = cur_active && cur_data && (cyc == cur_n + WAIT + 1);
    if (e_ifv) exp_if_rdata = cur_rdata;
    if (e_dv && !cur_we) exp_d_rdata = cur_rdata;

    check("if_gnt",      32'(bus.if_gnt),      32'(e_ifg));
    check("d_gnt",       32'(bus.d_gnt),       32'(e_dg));
    check("if_valid",    32'(bus.if_valid),    32'(e_ifv));
    check("d_valid",     32'(bus.d_valid),     32'(e_dv));
    check("if_rdata",    32'(bus.if_rdata),    32'(exp_if_rdata));
    check("d_rdata",     32'(bus.d_rdata),     32'(exp_d_rdata));
    check("mem_en",      32'(bus.mem_en),      32'(e_en));
    check("mem_we",      32'(bus.mem_we),      32'(e_we));
    check("busy",        32'(bus.busy),        32'(e_en));
    check("stall_fetch", 32'(bus.stall_fetch), 32'(bus.if_req & ~e_ifv));
    if (e_en)  check("mem_addr",   32'(bus.mem_addr),  32'(cur_addr));
    if (e_we)  check("mem_wdata",  32'(bus.mem_wdata), 32'(cur_wdata));
    if (e_ifg) check("starve_clr", 32'(u_dut.u_starve.count), 32'(0));

    if (bus.if_gnt) begin
      gnt_log.push_back("F");
      last_ifgnt_cyc = cyc;
      if (auto_drop) drop_if = 1'b1;
    end
    if (bus.d_gnt) begin
      gnt_log.push_back("D");
      last_dgnt_cyc = cyc;
      if (auto_drop) drop_d = 1'b1;
    end
    if (bus.d_valid) begin
      dv_cnt++;
      last_dv_cyc = cyc;
    end
    if (bus.mem_we) we_cnt++;

    if (cyc >= next_idle && !bus.halt_sys) begin
      if (bus.d_req && (!bus.if_req || starve < STARVE)) begin
        cur_active = 1'b1;
        cur_data   = 1'b1;
        cur_n      = cyc;
        cur_we     = bus.d_we;
        cur_addr   = bus.d_addr & 16'hFFFE;
        cur_wdata  = bus.d_wdata;
        if (bus.d_we) ref_mem[cur_addr[8:1]] = bus.d_wdata;
        else          cur_rdata = ref_mem[cur_addr[8:1]];
        if (bus.if_req && starve < STARVE) starve++;
        next_idle = cyc + WAIT + 1;
      end else if (bus.if_req) begin
        cur_active = 1'b1;
        cur_data   = 1'b0;
        cur_n      = cyc;
        cur_we     = 1'b0;
        cur_addr   = bus.if_addr & 16'hFFFE;
        cur_rdata  = ref_mem[cur_addr[8:1]];
        starve     = 0;
        next_idle  = cyc + WAIT + 1;
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    cyc++;
    if (drop_if) begin bus.if_req = 1'b0; drop_if = 1'b0; end
    if (drop_d)  begin bus.d_req  = 1'b0; drop_d  = 1'b0; end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      eval();
      advance();
    end
  endtask

  initial begin
    int          t0;
    logic [15:0] prior_d_rdata;

    rst = 1'b1;
    mem_init = 1'b1;
    bus.halt_sys = 1'b0;
    bus.if_req = 1'b0;
    bus.if_addr = '0;
    bus.d_req = 1'b0;
    bus.d_we = 1'b0;
    bus.d_addr = '0;
    bus.d_wdata = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 16'($urandom);
    ref_mem[2] = 16'h1234;

    // Reset state
    @(posedge clk);
    @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;
    mem_init = 1'b0;
    cyc = 0;
    model_reset();

    // Single fetch of the word at 0x0004
    t0 = cyc;
    bus.if_req = 1'b1;
    bus.if_addr = 16'h0004;
    step(WAIT + 3);
    check("fetch_rdata", 32'(bus.if_rdata), 32'h1234);
    check("fetch_gnt_cycle", 32'(last_ifgnt_cyc), 32'(t0 + 1));

    // Simultaneous fetch and odd-address load: data first, fetch in the next idle cycle
    t0 = cyc;
    bus.if_req = 1'b1;
    bus.if_addr = 16'h0040;
    bus.d_req = 1'b1;
    bus.d_we = 1'b0;
    bus.d_addr = 16'h0101;
    step(1);
    eval();
    check("sim_d_gnt", 32'(bus.d_gnt), 32'(1));
    check("sim_mem_addr", 32'(bus.mem_addr), 32'h0100);
    advance();
    step(2 * WAIT + 3);
    check("sim_dvalid_cycle", 32'(last_dv_cyc), 32'(t0 + WAIT + 1));
    check("sim_ifgnt_cycle", 32'(last_ifgnt_cyc), 32'(t0 + WAIT + 2));

    // Store of 0xBEEF to 0x0020
    we_cnt = 0;
    dv_cnt = 0;
    prior_d_rdata = exp_d_rdata;
    bus.d_req = 1'b1;
    bus.d_we = 1'b1;
    bus.d_addr = 16'h0020;
    bus.d_wdata = 16'hBEEF;
    step(WAIT + 3);
    check("store_we_cycles", 32'(we_cnt), 32'(WAIT));
    check("store_dvalid_count", 32'(dv_cnt), 32'(1));
    check("store_mem_word", 32'(mem[8'h10]), 32'hBEEF);
    check("store_d_rdata", 32'(bus.d_rdata), 32'(prior_d_rdata));

    // halt_sys raised during a fetch with a data request pending
    t0 = cyc;
    last_dgnt_cyc = -1;
    bus.if_req = 1'b1;
    bus.if_addr = 16'h0008;
    step(2);
    bus.d_req = 1'b1;
    bus.d_we = 1'b0;
    bus.d_addr = 16'h0030;
    for (int k = 2; k <= 8; k++) begin
      bus.halt_sys = (k < 7);
      step(1);
    end
    check("halt_dgnt_cycle", 32'(last_dgnt_cyc), 32'(t0 + 8));
    check("halt_fetch_rdata", 32'(bus.if_rdata), 32'(ref_mem[8'h04]));
    step(WAIT + 2);

    // Both requests held continuously: D,D,D,D,F,D
    auto_drop = 1'b0;
    gnt_log.delete();
    bus.if_req = 1'b1;
    bus.if_addr = 16'h0002;
    bus.d_req = 1'b1;
    bus.d_we = 1'b0;
    bus.d_addr = 16'h0044;
    step(6 * (WAIT + 1) + 1);
    check("starve_grant_count", 32'(gnt_log.size() >= 6), 32'(1));
    for (int i = 0; i < 6; i++) begin
      check($sformatf("starve_seq%0d", i), 32'(gnt_log[i]), 32'(exp_seq[i]));
    end
    bus.if_req = 1'b0;
    bus.d_req = 1'b0;
    auto_drop = 1'b1;
    step(WAIT + 2);

    // Reset asserted in the middle of a fetch
    bus.if_req = 1'b1;
    bus.if_addr = 16'h0010;
    step(2);
    eval();
    #2;
    rst = 1'b1;
    bus.if_req = 1'b0;
    #1;
    check_idle_outputs("rst_mid");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst_hold_if_valid", 32'(bus.if_valid), 32'(0));
      check("rst_hold_mem_en", 32'(bus.mem_en), 32'(0));
    end
    rst = 1'b0;
    cyc++;
    model_reset();

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      if (!bus.if_req && $urandom_range(0, 3) == 0) begin
        bus.if_req = 1'b1;
        bus.if_addr = 16'($urandom_range(0, 511));
      end
      if (!bus.d_req && $urandom_range(0, 3) == 0) begin
        bus.d_req = 1'b1;
        bus.d_we = 1'($urandom_range(0, 1));
        bus.d_addr = 16'($urandom_range(0, 511));
        bus.d_wdata = 16'($urandom);
      end
      bus.halt_sys = ($urandom_range(0, 7) == 0);
      step(1);
    end
    bus.halt_sys = 1'b0;
    bus.if_req = 1'b0;
    bus.d_req = 1'b0;
    step(WAIT + 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported 16-bit unified memory between the stage-one instruction fetch port and the stage-three data port (load/store).
- Sequences each access over a fixed number of memory wait cycles and returns read data.
- Raises stall_fetch toward the PC register and hazard logic while a fetch is pending.
- Sits between stage_one/stage-three and the physical memory model.

Parameters:
- WAIT_CYCLES, 1, memory access latency in cycles; legal range 1..15; 0 is an elaboration error.
- STARVE_LIMIT, 4, consecutive data grants made while a fetch is waiting before fetch is forced to win; legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- halt_sys  in  1  blocks new grants; an in-flight access completes
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  16  fetch byte address
- if_gnt  out  1  one-cycle pulse: fetch accepted
- if_valid  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  16  fetched instruction
- d_req  in  1  data request; held until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  16  data byte address
- d_wdata  in  16  store data
- d_gnt  out  1  one-cycle pulse: data access accepted
- d_valid  out  1  one-cycle pulse: load data valid or store done
- d_rdata  out  16  load data
- mem_en  out  1  memory access active
- mem_we  out  1  memory write strobe
- mem_addr  out  16  word-aligned address (bit 0 forced to 0)
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data, valid on the last wait cycle
- stall_fetch  out  1  fetch pending and not completing this cycle
- busy  out  1  FSM not in ARB_IDLE

Behaviour:
- Reset values:
  - All outputs 0; if_rdata and d_rdata are 0.
  - FSM in ARB_IDLE; wait counter 0; starve counter 0.
  - Reset asserted mid-access aborts it immediately: mem_en and mem_we drop asynchronously and no valid is issued.
- FSM states: ARB_IDLE, ARB_FETCH, ARB_DATA.
- ARB_IDLE, at a clock edge with halt_sys = 0:
  - Winner selection: if d_req and (!if_req or starve counter < STARVE_LIMIT), data wins. Otherwise, if if_req, fetch wins.
  - The winner's request (we, addr, wdata) is captured.
  - Wait counter loads WAIT_CYCLES-1.
  - Next state is ARB_DATA or ARB_FETCH.
  - The winner's gnt is registered high for exactly the next cycle.
- ARB_IDLE with halt_sys = 1: no grant; stays in ARB_IDLE.
- Access states:
  - mem_en = 1 every cycle; mem_addr and mem_wdata come from the captured registers.
  - mem_we = captured we in ARB_DATA; always 0 in ARB_FETCH.
  - The wait counter decrements each cycle.
  - In the cycle the counter equals 0: capture mem_rdata into the winner's rdata register (data port loads only; stores leave d_rdata unchanged), return to ARB_IDLE, and pulse the winner's valid in the following cycle.
- Latency:
  - Request sampled in ARB_IDLE at cycle N.
  - gnt at N+1.
  - mem_en during N+1 .. N+WAIT_CYCLES.
  - valid at N+WAIT_CYCLES+1, which is an ARB_IDLE cycle that can accept a new request.
  - Peak throughput: one access per WAIT_CYCLES+1 cycles.
- Starve counter:
  - Increments, saturating at STARVE_LIMIT, on each data grant while if_req = 1.
  - Clears on every fetch grant.
  - Unchanged otherwise.
- stall_fetch = if_req & ~if_valid (combinational, the only unregistered output).
- busy = (state != ARB_IDLE).
- rdata registers hold their value until the next completing read on that port.
- halt_sys asserted mid-access does not stretch the access.
- Requests arriving in non-idle states are not sampled. Requesters hold them until gnt.
- An address with bit 0 = 1 is accessed as the aligned word.
- A store must not assert d_valid before the write strobe is complete.

Decomposition:
- types_pkg gains:
  - arb_state_e (ARB_IDLE, ARB_FETCH, ARB_DATA)
  - memreq_t struct {we, addr[15:0], wdata[15:0]}
- Natural sub-module: arb_wait_counter. It is a loadable 4-bit down-counter with load, load value, and zero flag, and is reused for the starve counter as an up-counter variant via a DIR parameter.

Test Plan:
- Reset during an access:
  - Stimulus: WAIT_CYCLES=2; assert if_req with if_addr=0x0010 at cycle 0; assert rst at cycle 2.
  - Required: mem_en falls without waiting for a clock edge; no if_valid; busy=0; if_rdata=0.
- Single fetch:
  - Stimulus: WAIT_CYCLES=1; if_addr=0x0004 with mem word 0x1234.
  - Required: if_gnt at cycle 1; mem_en cycle 1 only; if_valid with if_rdata=0x1234 at cycle 2; stall_fetch high cycles 0-1, low at cycle 2.
- Simultaneous requests:
  - Stimulus: if_req and d_req (load, d_addr=0x0101) both at cycle 0.
  - Required: d_gnt first; mem_addr=0x0100; d_valid at cycle 2. The fetch is then granted in the cycle-2 idle state and if_gnt rises at cycle 3.
- Starvation limit:
  - Stimulus: STARVE_LIMIT=4; d_req and if_req held continuously.
  - Required: grants are D,D,D,D,F,D,...; the starve counter reads 0 after the fetch grant.
- Store:
  - Stimulus: WAIT_CYCLES=3; d_we=1, d_addr=0x0020, d_wdata=0xBEEF.
  - Required: mem_we=1 for exactly 3 cycles; the memory word updates; d_valid pulses once; d_rdata unchanged.
- halt_sys:
  - Stimulus: halt_sys raised during an ARB_FETCH access with d_req pending.
  - Required: the fetch completes normally; no d_gnt while halt_sys=1; d_gnt one cycle after halt_sys falls.
